uart_tx_fifo_cfg: RTL and testbench
===================================

// Module: uart_tx_fifo_cfg
// PURPOSE
//  Parametrised UART transmitter: buffers DATA_BITS words in a FIFO and serialises each word as a frame.
//  Frame: start bit, data bits LSB first, optional parity bit, then STOP_BITS stop bits.
//  Sits between the AES-128 core output path and the serial pin.
//  Supports valid/ready ingress and back-to-back frames with no idle gap.
// PARAMETERS
//  CLKS_PER_BIT  434  clocks per serial bit; legal value >= 2
//  DATA_BITS     8    data bits per frame; legal range 5..9
//  PARITY        0    0 = none, 1 = even, 2 = odd
//  STOP_BITS     1    stop bits per frame; 1 or 2
//  FIFO_DEPTH    4    ingress FIFO entries; power of 2, >= 2
// PORTS
//  clk            in   1                        system clock
//  reset_n        in   1                        synchronous, active-low reset
//  tx_valid       in   1                        tx_byte_in valid
//  tx_ready       out  1                        FIFO can accept; = (fifo_count < FIFO_DEPTH)
//  tx_byte_in     in   DATA_BITS                word to send
//  tx_serial_out  out  1                        serial line, idle high
//  tx_active      out  1                        frame in progress
//  tx_done        out  1                        1-cycle pulse at end of each frame
//  fifo_count     out  $clog2(FIFO_DEPTH)+1     words buffered (excludes frame in flight)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk):
//   - tx_serial_out=1; tx_active=0; tx_done=0; fifo_count=0.
//   - FIFO flushed; FSM=IDLE; counters cleared.
//   - Mid-frame reset aborts the frame; line is high after that edge.
//  Ingress:
//   - Push when tx_valid&&tx_ready at posedge.
//   - tx_ready is combinational from fifo_count only, so no push when full.
//   - Push and pop on the same edge: fifo_count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
//  IDLE:
//   - FIFO non-empty: pop into shift reg, ->START, line<=0, tx_active<=1.
//   - Latency: word pushed into empty FIFO at edge N drives the line low at edge N+1.
//  Bit timing: every bit is held exactly CLKS_PER_BIT cycles.
//   - clk_count is $clog2(CLKS_PER_BIT) wide; it runs 0..CLKS_PER_BIT-1, then wraps to 0 on the bit boundary.
//  START -> DATA after CLKS_PER_BIT cycles.
//  DATA:
//   - bit_index ($clog2(DATA_BITS+1) wide) steps 0..DATA_BITS-1.
//   - After the last bit: ->PARITY if PARITY!=0, else ->STOP.
//  PARITY: line = ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles, then ->STOP.
//  STOP:
//   - Line high for STOP_BITS*CLKS_PER_BIT cycles.
//   - On the final cycle: tx_done<=1 for one cycle.
//   - If the FIFO is non-empty: pop, ->START, line low on the next edge, tx_active stays 1 (no idle gap).
//   - Else: ->IDLE, tx_active<=0.
//  Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
//  tx_byte_in is captured at push; later changes do not affect queued or in-flight words.
//  Illegal or unreachable state: outputs forced to X in simulation; FSM recovers to IDLE on reset.
// TESTING
//  1) Defaults except CLKS_PER_BIT=4, PARITY=1. Push 0xA5 ->
//     line 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; tx_done at cycle 44 after start.
//  2) PARITY=2, DATA_BITS=7, STOP_BITS=2. Push 0x55 ->
//     odd parity bit=1; 2 stop bits; frame = 11*CLKS_PER_BIT cycles.
//  3) Push 0x01,0x02,0x03 back-to-back ->
//     three contiguous frames; line never idles between them; tx_active held high; 3 tx_done pulses.
//  4) FIFO_DEPTH=4, hold tx_valid for 6 words while frame 1 sends ->
//     tx_ready drops at fifo_count=4; no word lost or duplicated; output order matches input.
//  5) Pop and push on the same edge with FIFO full-1 -> fifo_count unchanged; data order preserved.
//  6) Assert reset_n=0 mid DATA bit 3 ->
//     next edge: line=1, tx_active=0, fifo_count=0; after release, a new push sends a clean frame.

Source files
------------

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: buffered UART transmitter with configurable framing.
// Words queue in a small FIFO and leave back-to-back with no idle gap.
module uart_tx_fifo_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_byte_in,
    output logic                        tx_serial_out,
    output logic                        tx_active,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        clk_count;
    logic [BW-1:0]        bit_index;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;

    assign tx_ready = (fifo_count < FULL);
    assign push     = tx_valid && tx_ready;
    assign head     = mem[rd_ptr];
    assign head_par = (PARITY == 2) ? ~^head : ^head;

    assign bit_end  = (clk_count == CLK_LAST);
    assign stop_end = (state == S_STOP) && bit_end &&
                      (stop_idx == STOP_LAST);
    // Pop either to start from idle or to chain the next frame.
    assign pop      = (fifo_count != '0) &&
                      ((state == S_IDLE) || stop_end);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            clk_count     <= '0;
            bit_index     <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            par_q         <= 1'b0;
            tx_serial_out <= 1'b1;
            tx_active     <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    clk_count <= '0;
                    if (pop) begin
                        shreg         <= head;
                        par_q         <= head_par;
                        state         <= S_START;
                        tx_serial_out <= 1'b0;
                        tx_active     <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_count     <= '0;
                        bit_index     <= '0;
                        tx_serial_out <= shreg[0];
                        shreg         <= shreg >> 1;
                        state         <= S_DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_count <= '0;
                        if (bit_index == BIT_LAST) begin
                            if (PARITY != 0) begin
                                state         <= S_PARITY;
                                tx_serial_out <= par_q;
                            end else begin
                                state         <= S_STOP;
                                stop_idx      <= 1'b0;
                                tx_serial_out <= 1'b1;
                            end
                        end else begin
                            bit_index     <= bit_index + 1'b1;
                            tx_serial_out <= shreg[0];
                            shreg         <= shreg >> 1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        clk_count     <= '0;
                        stop_idx      <= 1'b0;
                        state         <= S_STOP;
                        tx_serial_out <= 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_count <= '0;
                        if (stop_idx == STOP_LAST) begin
                            tx_done <= 1'b1;
                            // Chain straight into the next start bit.
                            if (pop) begin
                                shreg         <= head;
                                par_q         <= head_par;
                                state         <= S_START;
                                tx_serial_out <= 1'b0;
                            end else begin
                                state     <= S_IDLE;
                                tx_active <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    tx_serial_out <= 1'bx;
                    tx_active     <= 1'bx;
                    tx_done       <= 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg: framing, parity, chaining,
// FIFO backpressure, simultaneous push/pop and mid-frame reset.
module tb_uart_tx_fifo_cfg;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_ser, a_active, a_done;
    logic [7:0] a_data;
    logic [2:0] a_cnt;
    logic       b_valid, b_ready, b_ser, b_active, b_done;
    logic [6:0] b_data;
    logic [2:0] b_cnt;

    uart_tx_fifo_cfg #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(a_valid), .tx_ready(a_ready),
        .tx_byte_in(a_data), .tx_serial_out(a_ser),
        .tx_active(a_active), .tx_done(a_done),
        .fifo_count(a_cnt)
    );

    uart_tx_fifo_cfg #(
        .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(b_valid), .tx_ready(b_ready),
        .tx_byte_in(b_data), .tx_serial_out(b_ser),
        .tx_active(b_active), .tx_done(b_done),
        .fifo_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic rx_busy = 1'b0;
    int rx_t = 0;
    logic [10:0] rx_bits;
    logic [10:0] rx_q[$];
    logic [7:0] exp_words[$];
    int idx, bound, maxc;
    logic acc;
    logic [7:0] w4 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] w5 [5] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F};

    function automatic logic [10:0] frame_a(input logic [7:0] w);
        return {1'b1, ^w, w, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock; also runs a mid-bit sampling receiver on dut_a's line.
    task automatic step();
        @(negedge clk);
        if (!reset_n) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (a_ser === 1'b0) begin
                rx_busy = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % 4 == 2) rx_bits[rx_t / 4] = a_ser;
            if (rx_t == 42) begin
                rx_q.push_back(rx_bits);
                rx_busy = 1'b0;
            end
        end
        if (a_done === 1'b1) done_cnt++;
    endtask

    task automatic push_a(input logic [7:0] w);
        a_valid = 1'b1;
        a_data = w;
        step();
        a_valid = 1'b0;
    endtask

    task automatic frame_chk(input logic sel, input string tag,
                             input logic [10:0] want);
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("%s_bit%0d", tag, k),
                    sel ? b_ser : a_ser, want[k]);
                chk({tag, "_act"}, sel ? b_active : a_active, 1);
                chk({tag, "_done0"}, sel ? b_done : a_done, 0);
                step();
            end
        end
        chk({tag, "_done"}, sel ? b_done : a_done, 1);
        chk({tag, "_end_act"}, sel ? b_active : a_active, 0);
        chk({tag, "_end_line"}, sel ? b_ser : a_ser, 1);
        step();
        chk({tag, "_done_pulse"}, sel ? b_done : a_done, 0);
    endtask

    task automatic stream_chk(input string tag, input int n, input int t0);
        logic [10:0] fr;
        for (int t = t0; t <= 44 * n; t++) begin
            if (t < 44 * n) begin
                fr = frame_a(exp_words[t / 44]);
                chk($sformatf("%s_line_t%0d", tag, t), a_ser, fr[(t % 44) / 4]);
            end else begin
                chk({tag, "_idle"}, a_ser, 1);
            end
            chk({tag, "_act"}, a_active, (t < 44 * n) ? 1 : 0);
            chk({tag, "_done"}, a_done, (t > 0 && t % 44 == 0) ? 1 : 0);
            step();
        end
    endtask

    task automatic drain(input string tag, input int n, input int limit);
        int lim;
        lim = 0;
        while (done_cnt < n && lim < limit) begin
            step();
            lim++;
        end
        chk({tag, "_drain"}, done_cnt, n);
    endtask

    task automatic rx_chk(input string tag);
        chk({tag, "_rx_n"}, rx_q.size(), exp_words.size());
        for (int i = 0; i < rx_q.size() && i < exp_words.size(); i++) begin
            chk($sformatf("%s_rx%0d", tag, i), rx_q[i], frame_a(exp_words[i]));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0;
        a_data  = '0;
        b_valid = 1'b0;
        b_data  = '0;
        step();
        step();
        chk("rst_a_line", a_ser, 1);
        chk("rst_a_act", a_active, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_line", b_ser, 1);
        chk("rst_b_act", b_active, 0);
        chk("rst_b_cnt", b_cnt, 0);
        reset_n = 1'b1;
        step();

        // Even parity, 0xA5.
        push_a(8'hA5);
        chk("lat_line", a_ser, 1);
        chk("lat_cnt", a_cnt, 1);
        chk("lat_act", a_active, 0);
        step();
        frame_chk(1'b0, "par_even", 11'b10101001010);

        // Odd parity, 7 data bits, 2 stop bits, 0x55.
        b_valid = 1'b1;
        b_data = 7'h55;
        step();
        b_valid = 1'b0;
        chk("b_lat_line", b_ser, 1);
        chk("b_lat_cnt", b_cnt, 1);
        step();
        frame_chk(1'b1, "par_odd", 11'b11110101010);

        // Back-to-back frames.
        rx_q.delete();
        exp_words.delete();
        exp_words.push_back(8'h01);
        exp_words.push_back(8'h02);
        exp_words.push_back(8'h03);
        done_cnt = 0;
        a_valid = 1'b1;
        a_data = 8'h01;
        step();
        a_data = 8'h02;
        step();
        a_data = 8'h03;
        step();
        a_valid = 1'b0;
        chk("b2b_cnt", a_cnt, 2);
        stream_chk("b2b", 3, 1);
        chk("b2b_dones", done_cnt, 3);
        rx_chk("b2b");

        // Backpressure: six words offered into a 4-deep FIFO.
        rx_q.delete();
        exp_words.delete();
        for (int i = 0; i < 6; i++) exp_words.push_back(w4[i]);
        done_cnt = 0;
        idx = 0;
        bound = 0;
        maxc = 0;
        a_valid = 1'b1;
        a_data = w4[0];
        while (idx < 6 && bound < 200) begin
            acc = a_ready;
            step();
            bound++;
            if (acc) begin
                idx++;
                if (idx < 6) a_data = w4[idx];
            end
            if (int'(a_cnt) > maxc) maxc = int'(a_cnt);
            if (a_cnt == 3'd4) chk("full_ready", a_ready, 0);
        end
        a_valid = 1'b0;
        chk("fill_words", idx, 6);
        chk("fill_cycles", bound, 47);
        chk("fill_max", maxc, 4);
        drain("fill", 6, 400);
        chk("fill_end_act", a_active, 0);
        chk("fill_end_cnt", a_cnt, 0);
        rx_chk("fill");

        // Push and pop on the same edge at FIFO_DEPTH-1.
        rx_q.delete();
        exp_words.delete();
        for (int i = 0; i < 5; i++) exp_words.push_back(w5[i]);
        done_cnt = 0;
        a_valid = 1'b1;
        a_data = w5[0];
        step();
        a_data = w5[1];
        step();
        a_data = w5[2];
        step();
        a_data = w5[3];
        step();
        a_valid = 1'b0;
        chk("pp_pre_cnt", a_cnt, 3);
        chk("pp_pre_ready", a_ready, 1);
        repeat (41) step();
        chk("pp_t43_cnt", a_cnt, 3);
        chk("pp_t43_line", a_ser, 1);
        chk("pp_t43_done", a_done, 0);
        a_valid = 1'b1;
        a_data = w5[4];
        step();
        a_valid = 1'b0;
        chk("pp_cnt", a_cnt, 3);
        chk("pp_done", a_done, 1);
        chk("pp_line", a_ser, 0);
        chk("pp_act", a_active, 1);
        drain("pp", 5, 400);
        chk("pp_end_cnt", a_cnt, 0);
        rx_chk("pp");

        // Reset during data bit 3, with one word still queued.
        rx_q.delete();
        exp_words.delete();
        done_cnt = 0;
        a_valid = 1'b1;
        a_data = 8'hA5;
        step();
        a_data = 8'h3C;
        step();
        a_valid = 1'b0;
        repeat (17) step();
        chk("mid_bit3", a_ser, 0);
        chk("mid_cnt", a_cnt, 1);
        reset_n = 1'b0;
        step();
        chk("mrst_line", a_ser, 1);
        chk("mrst_act", a_active, 0);
        chk("mrst_cnt", a_cnt, 0);
        chk("mrst_done", a_done, 0);
        chk("mrst_ready", a_ready, 1);
        reset_n = 1'b1;
        rx_q.delete();
        repeat (6) step();
        chk("post_line", a_ser, 1);
        chk("post_act", a_active, 0);
        chk("post_cnt", a_cnt, 0);
        exp_words.push_back(8'h96);
        push_a(8'h96);
        drain("post", 1, 100);
        rx_chk("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
